rv_multicycle_control: RTL and testbench
========================================

Name: rv_multicycle_control

Overview:
Multi-cycle successor to the combinational RV32 control unit. An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same datapath control bundle, qualified per state. It adds a ready/request memory handshake, a wait-state timeout, and sticky trap reporting. It sits between the shared instruction/data memory port and the single-ported datapath; the datapath holds the IR and an old-PC register.

Parameters:
OPC_W, 6, opcode width (instr[6:1]; instr[0] is implied 1).
ALU_SEL_W, 3, width of ALUSel.
MEM_TIMEOUT, 16, consecutive not-ready cycles before a bus fault; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
opcode  in  OPC_W  IR opcode field
funct7  in  1  instr[30]
funct3  in  3  IR funct3
BrRes  in  1  branch comparator result (1 = taken)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
PCWrite  out  1  PC register load enable
IRWrite  out  1  IR and old-PC capture enable
PCSel  out  1  0 = PC+4, 1 = ALU result
ImmSel  out  3  I=000, S=001, B=010, U=011, J=100
RegWEn  out  1  register file write
Bsel  out  1  0 = rs2, 1 = immediate
Asel  out  1  0 = rs1, 1 = old-PC
ALUSel  out  ALU_SEL_W  ADD=0, SUB=1, AND=2, XOR=3, SRA=4, SLL=5, PASSB=6
MemW  out  1  store write strobe
WBSel  out  2  00 = memory, 01 = ALU, 10 = PC+4
Store_Select  out  1  1 = byte (sb), 0 = word
Load_Select  out  1  1 = lbu, 0 = lw
busy  out  1  high in every state except IDLE and TRAP
fault  out  2  00 none, 01 illegal opcode, 10 bus timeout; sticky

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state. Outputs are decoded from state plus fields latched in DECODE.
- Reset (async): state = IDLE, fields cleared, wait counter = 0, fault = 00. All outputs are 0.
- IDLE -> FETCH on the first clock edge after rst deasserts.
- FETCH: mem_req=1, Asel=0.
  - On mem_ready: IRWrite=1, PCWrite=1, PCSel=0, then go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle): latch opcode/funct3/funct7. Legal opcodes are 011001 R, 001001 I-ALU, 000001 load, 010001 store, 110001 branch, 011011 lui, 110111 jal.
  - Any other opcode, or R funct3 != 000 -> TRAP with fault=01.
  - Otherwise -> EXEC.
- EXEC: drives ALUSel/Bsel/Asel/ImmSel for the latched instruction.
  - R: add/sub selected by funct7.
  - I-ALU: funct3 000 ADD, 111 AND, 100 XOR, 101 SRA, 001 SLL; any other funct3 -> TRAP, fault=01.
  - load/store: ADD with Bsel=1, ImmSel I or S.
  - lui: PASSB, ImmSel U.
  - branch (bne): Asel=1, Bsel=1, ImmSel B, ADD; PCWrite=BrRes, PCSel=1.
  - jal: Asel=1, Bsel=1, ImmSel J, ADD; PCWrite=1, PCSel=1.
  - Next state: branch -> FETCH; load/store -> MEM; all others -> WB.
- MEM: mem_req=1, ALU address held. Store_Select = (funct3==000); Load_Select = (funct3==100).
  - Store: MemW=1 every cycle in MEM; -> FETCH on mem_ready.
  - Load: -> WB on mem_ready.
  - Otherwise stay and count.
- WB: RegWEn=1 for exactly one cycle, then -> FETCH. WBSel = 00 for load, 10 for jal, 01 otherwise.
- Wait counter: counts consecutive mem_ready=0 cycles in FETCH or MEM. It clears on mem_ready and on every state change.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready still 0 -> TRAP, fault=10, with no further mem_req.
  - mem_ready in that same cycle wins: no fault.
- TRAP: all strobes 0, busy=0. Exited only by rst.
- rst mid-instruction aborts immediately. Strobes drop asynchronously and no partial RegWEn/MemW is issued.
- Latency with zero-wait memory: ALU/lui/jal 4 cycles, load 5, store 4, branch 3.

Decomposition:
- Package rv_ctrl_pkg holds: opcode constants, ALUSel/ImmSel/WBSel encodings, fault codes, state encoding.
- One sub-module, rv_ctrl_decode: a purely combinational field decoder driving the per-instruction ALUSel/ImmSel/Bsel/Asel/WBSel/legal signals. The FSM qualifies its outputs by state.

Test Plan:
- add (011001, f7=0, f3=000), mem_ready=1 -> FETCH..WB in 4 cycles; ALUSel=0 in EXEC; a single RegWEn pulse with WBSel=01. Repeat with f7=1 -> ALUSel=1.
- lbu (000001, f3=100) with 3 wait cycles in MEM -> mem_req held for 4 cycles; Load_Select=1; RegWEn in WB with WBSel=00; 8 cycles total.
- sb (010001, f3=000) -> MemW=1 and Store_Select=1 in MEM; RegWEn never asserts.
- bne (110001, f3=001) with BrRes=0 -> PCWrite=0 in EXEC. Repeat with BrRes=1 -> PCWrite=1, PCSel=1; next state FETCH after 3 cycles.
- Opcode 111111 -> TRAP after DECODE, fault=01, busy=0 and held. I-ALU f3=010 -> fault=01.
- MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> TRAP after 4 request cycles, fault=10. Then rst mid-MEM of a later sw -> all outputs 0 immediately and restart from IDLE.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit: opcodes, datapath
// select codes, fault codes, FSM states and instruction classes.
package rv_ctrl_pkg;

  localparam logic [5:0] OP_R      = 6'b011001;
  localparam logic [5:0] OP_IALU   = 6'b001001;
  localparam logic [5:0] OP_LOAD   = 6'b000001;
  localparam logic [5:0] OP_STORE  = 6'b010001;
  localparam logic [5:0] OP_BRANCH = 6'b110001;
  localparam logic [5:0] OP_LUI    = 6'b011011;
  localparam logic [5:0] OP_JAL    = 6'b110111;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_XOR   = 3'd3;
  localparam logic [2:0] ALU_SRA   = 3'd4;
  localparam logic [2:0] ALU_SLL   = 3'd5;
  localparam logic [2:0] ALU_PASSB = 3'd6;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_ILL  = 2'b01;
  localparam logic [1:0] FLT_BUS  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_JAL, C_BAD
  } iclass_e;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational field decoder: maps opcode/funct3/funct7 to the per-instruction
// datapath selects and legality flags. The FSM decides when they are driven.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7_i,
  output iclass_e          iclass_o,
  output logic [2:0]       alu_sel_o,
  output logic [2:0]       imm_sel_o,
  output logic             bsel_o,
  output logic             asel_o,
  output logic [1:0]       wb_sel_o,
  output logic             legal_op_o,
  output logic             legal_f3_o
);

  always_comb begin
    iclass_o   = C_BAD;
    alu_sel_o  = ALU_ADD;
    imm_sel_o  = IMM_I;
    bsel_o     = 1'b0;
    asel_o     = 1'b0;
    wb_sel_o   = WB_ALU;
    legal_op_o = 1'b1;
    legal_f3_o = 1'b1;
    case (opcode_i)
      OP_R: begin
        iclass_o   = C_R;
        alu_sel_o  = funct7_i ? ALU_SUB : ALU_ADD;
        legal_op_o = (funct3_i == 3'b000);
      end
      OP_IALU: begin
        iclass_o = C_IALU;
        bsel_o   = 1'b1;
        // Only funct3 values with an ALU op are legal; the rest trap in EXEC.
        case (funct3_i)
          3'b000:  alu_sel_o = ALU_ADD;
          3'b111:  alu_sel_o = ALU_AND;
          3'b100:  alu_sel_o = ALU_XOR;
          3'b101:  alu_sel_o = ALU_SRA;
          3'b001:  alu_sel_o = ALU_SLL;
          default: legal_f3_o = 1'b0;
        endcase
      end
      OP_LOAD: begin
        iclass_o = C_LOAD;
        bsel_o   = 1'b1;
        wb_sel_o = WB_MEM;
      end
      OP_STORE: begin
        iclass_o  = C_STORE;
        bsel_o    = 1'b1;
        imm_sel_o = IMM_S;
      end
      OP_BRANCH: begin
        iclass_o  = C_BRANCH;
        asel_o    = 1'b1;
        bsel_o    = 1'b1;
        imm_sel_o = IMM_B;
      end
      OP_LUI: begin
        iclass_o  = C_LUI;
        bsel_o    = 1'b1;
        imm_sel_o = IMM_U;
        alu_sel_o = ALU_PASSB;
      end
      OP_JAL: begin
        iclass_o  = C_JAL;
        asel_o    = 1'b1;
        bsel_o    = 1'b1;
        imm_sel_o = IMM_J;
        wb_sel_o  = WB_PC4;
      end
      default: legal_op_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_control.sv
// Multi-cycle RV32 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port with a wait-state timeout and sticky trap reporting.
//
// state  | meaning
// IDLE   | out of reset, no activity
// FETCH  | instruction request; IR/PC load on mem_ready
// DECODE | fields latched, legality checked
// EXEC   | ALU op driven; branch/jal update PC
// MEM    | load/store data access
// WB     | one-cycle register file write
// TRAP   | fault recorded, parked until reset
module rv_multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter int ALU_SEL_W   = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPC_W-1:0]     opcode,
  input  logic                 funct7,
  input  logic [2:0]           funct3,
  input  logic                 BrRes,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 PCSel,
  output logic [2:0]           ImmSel,
  output logic                 RegWEn,
  output logic                 Bsel,
  output logic                 Asel,
  output logic [ALU_SEL_W-1:0] ALUSel,
  output logic                 MemW,
  output logic [1:0]           WBSel,
  output logic                 Store_Select,
  output logic                 Load_Select,
  output logic                 busy,
  output logic [1:0]           fault
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opcode_q;
  logic [2:0]         funct3_q;
  logic               funct7_q;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic [1:0]         fault_q, fault_d;

  logic [OPC_W-1:0]   dec_opcode;
  logic [2:0]         dec_funct3;
  logic               dec_funct7;
  iclass_e            dec_class;
  logic [2:0]         dec_alu, dec_imm;
  logic               dec_bsel, dec_asel, dec_legal_op, dec_legal_f3;
  logic [1:0]         dec_wb;
  logic               timeout_hit, drive_dp;

  // In DECODE the decoder looks at the live IR so the legality check needs no extra cycle.
  assign dec_opcode = (state_q == S_DECODE) ? opcode : opcode_q;
  assign dec_funct3 = (state_q == S_DECODE) ? funct3 : funct3_q;
  assign dec_funct7 = (state_q == S_DECODE) ? funct7 : funct7_q;

  rv_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode_i   (dec_opcode),
    .funct3_i   (dec_funct3),
    .funct7_i   (dec_funct7),
    .iclass_o   (dec_class),
    .alu_sel_o  (dec_alu),
    .imm_sel_o  (dec_imm),
    .bsel_o     (dec_bsel),
    .asel_o     (dec_asel),
    .wb_sel_o   (dec_wb),
    .legal_op_o (dec_legal_op),
    .legal_f3_o (dec_legal_f3)
  );

  assign wait_inc    = (MEM_TIMEOUT > 0) ? wait_q + 1'b1 : '0;
  assign timeout_hit = (MEM_TIMEOUT > 0) && !mem_ready &&
                       (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    fault_d      = fault_q;
    drive_dp     = 1'b0;
    mem_req      = 1'b0;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    PCSel        = 1'b0;
    RegWEn       = 1'b0;
    MemW         = 1'b0;
    WBSel        = 2'b00;
    Store_Select = 1'b0;
    Load_Select  = 1'b0;
    busy         = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          fault_d = FLT_BUS;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        if (!dec_legal_op) begin
          state_d = S_TRAP;
          fault_d = FLT_ILL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy = 1'b1;
        if (!dec_legal_f3) begin
          state_d = S_TRAP;
          fault_d = FLT_ILL;
        end else begin
          drive_dp = 1'b1;
          case (dec_class)
            C_BRANCH: begin
              PCWrite = BrRes;
              PCSel   = 1'b1;
              state_d = S_FETCH;
            end
            C_JAL: begin
              PCWrite = 1'b1;
              PCSel   = 1'b1;
              state_d = S_WB;
            end
            C_LOAD, C_STORE: state_d = S_MEM;
            default:         state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        busy         = 1'b1;
        mem_req      = 1'b1;
        drive_dp     = 1'b1;
        Store_Select = (funct3_q == 3'b000);
        Load_Select  = (funct3_q == 3'b100);
        MemW         = (dec_class == C_STORE);
        if (mem_ready) begin
          state_d = (dec_class == C_STORE) ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          fault_d = FLT_BUS;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        busy     = 1'b1;
        drive_dp = 1'b1;
        RegWEn   = 1'b1;
        WBSel    = dec_wb;
        state_d  = S_FETCH;
      end
      S_TRAP:  ;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU operand/op selects stay valid from EXEC through WB for the result path.
  assign ALUSel = drive_dp ? ALU_SEL_W'(dec_alu) : '0;
  assign ImmSel = drive_dp ? dec_imm : 3'b000;
  assign Bsel   = drive_dp & dec_bsel;
  assign Asel   = drive_dp & dec_asel;
  assign fault  = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      funct3_q <= '0;
      funct7_q <= 1'b0;
      wait_q   <= '0;
      fault_q  <= FLT_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
        funct3_q <= funct3;
        funct7_q <= funct7;
      end
    end
  end

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Scoreboard bench for rv_multicycle_control: each cycle's expected output
// vector is queued with the stimulus and compared on the following falling edge.
module tb_rv_multicycle_control;

  localparam logic [5:0] O_R = 6'b011001, O_I = 6'b001001, O_LD = 6'b000001,
                         O_ST = 6'b010001, O_BR = 6'b110001, O_LUI = 6'b011011,
                         O_JAL = 6'b110111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       funct7 = 1'b0;
  logic [2:0] funct3 = '0;
  logic       BrRes = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, PCWrite, IRWrite, PCSel, RegWEn, Bsel, Asel, MemW;
  logic       Store_Select, Load_Select, busy;
  logic [2:0] ImmSel, ALUSel;
  logic [1:0] WBSel, fault;
  logic [20:0] outs;

  int total = 0;
  int bad   = 0;

  typedef struct { string tag; logic [20:0] v; } exp_t;
  exp_t sb[$];

  rv_multicycle_control #(.OPC_W(6), .ALU_SEL_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .BrRes(BrRes), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .PCSel(PCSel), .ImmSel(ImmSel), .RegWEn(RegWEn),
    .Bsel(Bsel), .Asel(Asel), .ALUSel(ALUSel), .MemW(MemW), .WBSel(WBSel),
    .Store_Select(Store_Select), .Load_Select(Load_Select), .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, PCWrite, IRWrite, PCSel, ImmSel, RegWEn, Bsel, Asel,
                 ALUSel, MemW, WBSel, Store_Select, Load_Select, busy, fault};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, {11'b0, outs}, {11'b0, e.v});
    end
  end

  function automatic logic [20:0] mk(input logic req, pcw, irw, pcsel,
                                     input logic [2:0] imm, input logic regw, bs, as,
                                     input logic [2:0] alu, input logic memw,
                                     input logic [1:0] wb, input logic ss, ls, bsy,
                                     input logic [1:0] flt);
    return {req, pcw, irw, pcsel, imm, regw, bs, as, alu, memw, wb, ss, ls, bsy, flt};
  endfunction

  function automatic logic [20:0] e_fetch(input logic r);
    return mk(1, r, r, 0, 3'd0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0, 1, 2'd0);
  endfunction
  function automatic logic [20:0] e_dec();
    return mk(0, 0, 0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0, 1, 2'd0);
  endfunction
  function automatic logic [20:0] e_exec(input logic [2:0] imm, input logic bs, as,
                                         input logic [2:0] alu, input logic pcw, pcsel);
    return mk(0, pcw, 0, pcsel, imm, 0, bs, as, alu, 0, 2'd0, 0, 0, 1, 2'd0);
  endfunction
  function automatic logic [20:0] e_mem(input logic [2:0] imm, input logic memw, ss, ls);
    return mk(1, 0, 0, 0, imm, 0, 1, 0, 3'd0, memw, 2'd0, ss, ls, 1, 2'd0);
  endfunction
  function automatic logic [20:0] e_wb(input logic [2:0] imm, input logic bs, as,
                                       input logic [2:0] alu, input logic [1:0] wb);
    return mk(0, 0, 0, 0, imm, 1, bs, as, alu, 0, wb, 0, 0, 1, 2'd0);
  endfunction
  function automatic logic [20:0] e_trap(input logic [1:0] f);
    return mk(0, 0, 0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0, f);
  endfunction

  task automatic step(input string tag, input logic rdy, input logic br, input logic [20:0] e);
    exp_t x;
    mem_ready = rdy;
    BrRes     = br;
    x.tag     = tag;
    x.v       = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [2:0] f3, input logic f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // FETCH, DECODE, EXEC then WB with zero-wait memory
  task automatic run_wb(input string tag, input logic [5:0] op, input logic [2:0] f3,
                        input logic f7, input logic [2:0] imm, input logic bs, as,
                        input logic [2:0] alu, input logic pcw, input logic [1:0] wb);
    set_ir(op, f3, f7);
    step({tag, "_f"}, 1, 0, e_fetch(1));
    step({tag, "_d"}, 0, 0, e_dec());
    step({tag, "_e"}, 0, 0, e_exec(imm, bs, as, alu, pcw, pcw));
    step({tag, "_wb"}, 0, 0, e_wb(imm, bs, as, alu, wb));
  endtask

  task automatic pulse_rst(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_async"}, {11'b0, outs}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step({tag, "_idle"}, 0, 0, 21'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step("reset", 0, 0, 21'd0);
    rst = 1'b0;
    step("idle", 0, 0, 21'd0);

    run_wb("add", O_R, 3'b000, 0, 3'b000, 0, 0, 3'd0, 0, 2'b01);
    run_wb("sub", O_R, 3'b000, 1, 3'b000, 0, 0, 3'd1, 0, 2'b01);

    set_ir(O_LD, 3'b100, 0);
    step("lbu_f", 1, 0, e_fetch(1));
    step("lbu_d", 0, 0, e_dec());
    step("lbu_e", 0, 0, e_exec(3'b000, 1, 0, 3'd0, 0, 0));
    for (int i = 0; i < 3; i++) step("lbu_mwait", 0, 0, e_mem(3'b000, 0, 0, 1));
    step("lbu_mrdy", 1, 0, e_mem(3'b000, 0, 0, 1));
    step("lbu_wb", 0, 0, e_wb(3'b000, 1, 0, 3'd0, 2'b00));

    set_ir(O_ST, 3'b000, 0);
    step("sb_f", 1, 0, e_fetch(1));
    step("sb_d", 0, 0, e_dec());
    step("sb_e", 0, 0, e_exec(3'b001, 1, 0, 3'd0, 0, 0));
    step("sb_m", 1, 0, e_mem(3'b001, 1, 1, 0));

    set_ir(O_BR, 3'b001, 0);
    step("bne0_f", 1, 0, e_fetch(1));
    step("bne0_d", 0, 0, e_dec());
    step("bne0_e", 0, 0, e_exec(3'b010, 1, 1, 3'd0, 0, 1));
    step("bne1_f", 1, 0, e_fetch(1));
    step("bne1_d", 0, 0, e_dec());
    step("bne1_e", 0, 1, e_exec(3'b010, 1, 1, 3'd0, 1, 1));

    run_wb("lui", O_LUI, 3'b000, 0, 3'b011, 1, 0, 3'd6, 0, 2'b01);
    run_wb("jal", O_JAL, 3'b000, 0, 3'b100, 1, 1, 3'd0, 1, 2'b10);
    run_wb("xori", O_I, 3'b100, 0, 3'b000, 1, 0, 3'd3, 0, 2'b01);
    run_wb("srai", O_I, 3'b101, 0, 3'b000, 1, 0, 3'd4, 0, 2'b01);

    set_ir(O_I, 3'b010, 0);
    step("ibad_f", 1, 0, e_fetch(1));
    step("ibad_d", 0, 0, e_dec());
    step("ibad_e", 0, 0, e_dec());
    step("ibad_trap", 1, 0, e_trap(2'b01));
    step("ibad_hold", 1, 0, e_trap(2'b01));
    pulse_rst("rst1");

    set_ir(6'b111111, 3'b000, 0);
    step("opbad_f", 1, 0, e_fetch(1));
    step("opbad_d", 0, 0, e_dec());
    step("opbad_trap", 1, 0, e_trap(2'b01));
    step("opbad_hold", 1, 0, e_trap(2'b01));
    pulse_rst("rst2");

    set_ir(O_R, 3'b000, 0);
    for (int i = 0; i < 4; i++) step("tmo_f", 0, 0, e_fetch(0));
    step("tmo_trap", 0, 0, e_trap(2'b10));
    step("tmo_hold", 1, 0, e_trap(2'b10));
    pulse_rst("rst3");

    set_ir(O_ST, 3'b010, 0);
    step("sw_f", 1, 0, e_fetch(1));
    step("sw_d", 0, 0, e_dec());
    step("sw_e", 0, 0, e_exec(3'b001, 1, 0, 3'd0, 0, 0));
    step("sw_m0", 0, 0, e_mem(3'b001, 1, 0, 0));
    step("sw_m1", 0, 0, e_mem(3'b001, 1, 0, 0));
    pulse_rst("sw_rst");

    run_wb("add2", O_R, 3'b000, 0, 3'b000, 0, 0, 3'd0, 0, 2'b01);
    step("end_f", 1, 0, e_fetch(1));

    #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
